conv3d_3x3_multich: RTL
=======================

CONV3D_3X3_MULTICH -- requirements
Module: conv3d_3x3_multich

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed pixel and weight width.
REQ-002 SHALL have parameter CH, default 3, input channel count (1..8).
REQ-003 SHALL have parameter IMG_WIDTH, default 299, pixels per row (>=3).
REQ-004 SHALL have parameter IMG_HEIGHT, default 299, rows per frame (>=3).
REQ-005 SHALL have parameter STRIDE, default 2, window step in both axes (1 or 2).
REQ-006 SHALL have derived localparam ACC_W = 2*DATA_W + clog2(9*CH) + 1.
REQ-007 SHALL have port clk, input, 1, single clock, rising edge.
REQ-008 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-009 SHALL have port Data_In, input, CH*DATA_W, one pixel per channel, channel 0 in the LSBs.
REQ-010 SHALL have port Valid_In, input, 1, Data_In qualifier, raster order.
REQ-011 SHALL have port Kernel_We, input, 1, weight write strobe.
REQ-012 SHALL have port Kernel_Addr, input, clog2(9*CH), index = ch*9 + tap, tap 0..8 row-major.
REQ-013 SHALL have port Kernel_Data, input, DATA_W, weight value.
REQ-014 SHALL have port Bias, input, ACC_W, signed bias, sampled with each output.
REQ-015 SHALL have port Data_Out, output, ACC_W, signed convolution sum.
REQ-016 SHALL have port Valid_Out, output, 1, Data_Out qualifier.
REQ-017 SHALL have port Frame_Done, output, 1, one-cycle pulse after the last output of a frame.
REQ-018 SHALL have port Kernel_Err, output, 1, one-cycle pulse on a rejected weight write.

Function
REQ-019 SHALL keep two line buffers of IMG_WIDTH entries per channel and a 3x3 window per channel, shifting only on Valid_In=1.
REQ-020 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters, advancing on Valid_In; col wraps to 0 and increments row; both wrap to 0 after the last pixel.
REQ-021 SHALL run FSM IDLE -> FILL on the first accepted pixel; FILL -> RUN when row=2 and col=0; RUN -> IDLE after the last pixel of the frame is accepted.
REQ-022 SHALL issue a window when the pixel at (row, col) is accepted with row>=2, col>=2, (row-2)%STRIDE=0 and (col-2)%STRIDE=0.
REQ-023 SHALL compute sum over ch and taps of signed(pixel)*signed(weight), plus Bias, full precision in ACC_W, no saturation, two's-complement wrap.
REQ-024 SHALL use a fixed 3-stage pipeline (multiply, per-channel adder tree, cross-channel sum plus bias); Valid_Out asserts exactly 3 cycles after the issuing Valid_In.
REQ-025 SHALL hold Data_Out at its last value while Valid_Out=0.
REQ-026 SHALL tolerate arbitrary Valid_In gaps; gaps do not change results, only timing.
REQ-027 SHALL produce ((IMG_HEIGHT-3)/STRIDE+1)*((IMG_WIDTH-3)/STRIDE+1) outputs per frame.
REQ-028 SHALL pulse Frame_Done in the cycle after the frame's last Valid_Out.
REQ-029 SHALL accept weight writes only in IDLE; a write in FILL or RUN is ignored and pulses Kernel_Err one cycle later.
REQ-030 SHALL give a weight write priority over a simultaneous first Valid_In: the write lands and the pixel is accepted into FILL.

Reset
REQ-031 SHALL on rst clear counters, FSM to IDLE, pipeline valids, Data_Out=0, Valid_Out=0, Frame_Done=0, Kernel_Err=0.
REQ-032 SHALL retain weights through rst; line buffer contents are don't-care after rst.
REQ-033 SHALL on rst mid-frame discard all in-flight windows; no Valid_Out follows until a new frame produces one.

Configuration
REQ-034 SHALL, with CONV3D_RELU_EN defined, clamp negative final sums to 0 in stage 3 with no latency change.
REQ-035 SHALL, without CONV3D_RELU_EN, output the signed sum unmodified.

Structure
REQ-036 SHALL put ACC_W computation, tap-index constants and the FSM state enum in shared package conv_pkg.
REQ-037 SHALL instantiate one sub-module conv_line_window per channel (line buffers plus 3x3 window).

Verification
REQ-038 SHALL check CH=3, 5x5, STRIDE=2, all pixels 1, all weights 1, Bias 0 -> 4 outputs of 27, then Frame_Done.
REQ-039 SHALL check CH=1, 4x4, STRIDE=1, pixels 0..15 raster, centre weight 1 else 0, Bias 0 -> outputs 5,6,9,10.
REQ-040 SHALL check that same 4x4 case with Valid_In toggling every other cycle -> identical outputs, each 3 cycles after its issuing pixel.
REQ-041 SHALL check pixel -1, weight 1, CH=3, Bias 0 -> -27 without CONV3D_RELU_EN, 0 with it.
REQ-042 SHALL check Kernel_We asserted during RUN -> Kernel_Err pulse, weight unchanged, outputs unchanged.
REQ-043 SHALL check rst asserted mid-frame (row 3) -> Valid_Out=0 next cycle; next full frame yields correct count and values.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 multichannel convolution slice:
// accumulator sizing, window tap geometry and the frame-control FSM states.
package conv_pkg;

    localparam int TAP_ROWS = 3;
    localparam int TAP_COLS = 3;
    localparam int TAPS     = TAP_ROWS * TAP_COLS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } conv_state_t;

    // Full-precision sum of 9*ch signed products plus a signed bias.
    function automatic int acc_width(input int data_w, input int ch);
        return 2 * data_w + $clog2(TAPS * ch) + 1;
    endfunction

    // Row-major tap index inside the 3x3 window; row 0 is the oldest line.
    function automatic int tap_idx(input int r, input int c);
        return r * TAP_COLS + c;
    endfunction

endpackage

// File: rtl/conv_line_window.sv
// One channel of line storage: two previous-row buffers plus a 3x3 window whose
// newest column is taken combinationally from the incoming pixel and buffers.
module conv_line_window
    import conv_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int IMG_WIDTH = 299,
    localparam int COL_W    = $clog2(IMG_WIDTH)
) (
    input  logic                    clk,
    input  logic                    valid,
    input  logic [COL_W-1:0]        col,
    input  logic [DATA_W-1:0]       pix,
    output logic [TAPS*DATA_W-1:0]  win
);

    logic [DATA_W-1:0] lb_up1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb_up2 [IMG_WIDTH];
    logic [DATA_W-1:0] hist   [TAP_ROWS][TAP_COLS-1];
    logic [DATA_W-1:0] newcol [TAP_ROWS];

    always_comb begin
        newcol[0] = lb_up2[col];
        newcol[1] = lb_up1[col];
        newcol[2] = pix;
    end

    // Exposing the incoming column directly saves one register stage, so the
    // multiplier stage sees the complete window in the accepting cycle.
    always_comb begin
        win = '0;
        for (int unsigned r = 0; r < TAP_ROWS; r++) begin
            win[tap_idx(r, 0)*DATA_W +: DATA_W] = hist[r][0];
            win[tap_idx(r, 1)*DATA_W +: DATA_W] = hist[r][1];
            win[tap_idx(r, 2)*DATA_W +: DATA_W] = newcol[r];
        end
    end

    always_ff @(posedge clk) begin
        if (valid) begin
            lb_up1[col] <= pix;
            lb_up2[col] <= lb_up1[col];
            for (int unsigned r = 0; r < TAP_ROWS; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= newcol[r];
            end
        end
    end

endmodule

// File: rtl/conv3d_3x3_multich.sv
// Streaming 3x3 multichannel convolution with stride, bias and a 3-stage pipeline.
// Optional CONV3D_RELU_EN clamps negative sums to zero in the final stage.
module conv3d_3x3_multich
    import conv_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CH         = 3,
    parameter int IMG_WIDTH  = 299,
    parameter int IMG_HEIGHT = 299,
    parameter int STRIDE     = 2,
    localparam int ACC_W     = acc_width(DATA_W, CH),
    localparam int KA_W      = $clog2(TAPS * CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*DATA_W-1:0]  Data_In,
    input  logic                  Valid_In,
    input  logic                  Kernel_We,
    input  logic [KA_W-1:0]       Kernel_Addr,
    input  logic [DATA_W-1:0]     Kernel_Data,
    input  logic [ACC_W-1:0]      Bias,
    output logic [ACC_W-1:0]      Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done,
    output logic                  Kernel_Err
);

    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);
    localparam int NK       = TAPS * CH;
    localparam int PROD_W   = 2 * DATA_W;
    localparam int LAST_ROW = 2 + ((IMG_HEIGHT - 3) / STRIDE) * STRIDE;
    localparam int LAST_COL = 2 + ((IMG_WIDTH - 3) / STRIDE) * STRIDE;

    conv_state_t state, state_nx;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last, last_pix;
    logic             row_ok, col_ok, issue, issue_last;

    logic signed [DATA_W-1:0] kern [NK];
    logic [TAPS*DATA_W-1:0]   win  [CH];

    logic signed [PROD_W-1:0] prod    [CH][TAPS];
    logic signed [ACC_W-1:0]  chsum_d [CH];
    logic signed [ACC_W-1:0]  chsum   [CH];
    logic signed [ACC_W-1:0]  total_d;

    logic s1_v, s1_last, s2_v, s2_last, out_last;

    // Raster position of the pixel currently presented on Data_In.
    assign col_last = (col == COL_W'(IMG_WIDTH - 1));
    assign last_pix = col_last && (row == ROW_W'(IMG_HEIGHT - 1));

    // STRIDE is restricted to 1 or 2, so the modulo reduces to a parity test.
    assign row_ok     = (row >= ROW_W'(2)) && ((STRIDE == 1) || !row[0]);
    assign col_ok     = (col >= COL_W'(2)) && ((STRIDE == 1) || !col[0]);
    assign issue      = Valid_In && row_ok && col_ok;
    assign issue_last = issue && (row == ROW_W'(LAST_ROW)) && (col == COL_W'(LAST_COL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (col_last) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (Valid_In) state_nx = ST_FILL;
            ST_FILL: if (row == ROW_W'(2) && col == '0) state_nx = ST_RUN;
            ST_RUN:  if (Valid_In && last_pix) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Weights deliberately have no reset so they survive rst.
    always_ff @(posedge clk) begin
        if (Kernel_We && state == ST_IDLE && Kernel_Addr < KA_W'(NK))
            kern[Kernel_Addr] <= $signed(Kernel_Data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) Kernel_Err <= 1'b0;
        else     Kernel_Err <= Kernel_We && (state != ST_IDLE);
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        conv_line_window #(
            .DATA_W    (DATA_W),
            .IMG_WIDTH (IMG_WIDTH)
        ) u_win (
            .clk   (clk),
            .valid (Valid_In),
            .col   (col),
            .pix   (Data_In[g*DATA_W +: DATA_W]),
            .win   (win[g])
        );
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned t = 0; t < TAPS; t++)
                    prod[c][t] <= PROD_W'($signed(win[c][t*DATA_W +: DATA_W]))
                                * PROD_W'(kern[c*TAPS + t]);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CH; c++) begin
            chsum_d[c] = '0;
            for (int unsigned t = 0; t < TAPS; t++)
                chsum_d[c] = chsum_d[c] + ACC_W'(prod[c][t]);
        end
    end

    always_ff @(posedge clk) begin
        if (s1_v) begin
            for (int unsigned c = 0; c < CH; c++)
                chsum[c] <= chsum_d[c];
        end
    end

    always_comb begin
        total_d = $signed(Bias);
        for (int unsigned c = 0; c < CH; c++)
            total_d = total_d + chsum[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            s2_v       <= 1'b0;
            s2_last    <= 1'b0;
            Valid_Out  <= 1'b0;
            out_last   <= 1'b0;
            Frame_Done <= 1'b0;
            Data_Out   <= '0;
        end else begin
            s1_v       <= issue;
            s1_last    <= issue_last;
            s2_v       <= s1_v;
            s2_last    <= s1_v && s1_last;
            Valid_Out  <= s2_v;
            out_last   <= s2_v && s2_last;
            Frame_Done <= out_last;
            if (s2_v) begin
`ifdef CONV3D_RELU_EN
                Data_Out <= total_d[ACC_W-1] ? '0 : total_d;
`else
                Data_Out <= total_d;
`endif
            end
        end
    end

endmodule
